// File: rtl/ai_target_select.sv
// Shot selector: scans the 10x10 density map one cell per cycle and offers the
// highest-density unfired cell on a valid/ready handshake. Option: AI_PARITY_EN.
module ai_target_select (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [99:0][5:0] density,
  input  logic [99:0]     fired,
  input  logic            shot_ready,
  output logic            busy,
  output logic            shot_valid,
  output logic [6:0]      shot_pos,
  output logic [3:0]      shot_x,
  output logic [3:0]      shot_y,
  output logic [5:0]      shot_density,
  output logic            no_target
);

`ifdef AI_PARITY_EN
  localparam int KW = 7;
`else
  localparam int KW = 6;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, OFFER} state_t;

  state_t          state, state_nx;
  logic [6:0]      pos;
  logic [3:0]      x, y;
  logic            best_found;
  logic [KW-1:0]   best_key;
  logic [6:0]      best_pos;
  logic [3:0]      best_x, best_y;
  logic [5:0]      best_den;

  logic [5:0]      cur_den;
  logic [KW-1:0]   cur_key;
  logic            cand, take, last, found_nx;

  assign cur_den = density[pos];
`ifdef AI_PARITY_EN
  // Low key bit favours checkerboard cells (x+y even) among equal densities.
  assign cur_key = {cur_den, ~(x[0] ^ y[0])};
`else
  assign cur_key = cur_den;
`endif

  // Strict compare keeps the earliest (lowest-index) cell on equal keys.
  assign cand     = ~fired[pos];
  assign take     = cand && (!best_found || (cur_key > best_key));
  assign last     = (pos == 7'd99);
  assign found_nx = best_found | cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx; no latch is inferred.
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (last) state_nx = found_nx ? OFFER : IDLE;
      OFFER:   if (shot_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos          <= '0;
      x            <= '0;
      y            <= '0;
      best_found   <= 1'b0;
      best_key     <= '0;
      best_pos     <= '0;
      best_x       <= '0;
      best_y       <= '0;
      best_den     <= '0;
      busy         <= 1'b0;
      shot_valid   <= 1'b0;
      shot_pos     <= '0;
      shot_x       <= '0;
      shot_y       <= '0;
      shot_density <= '0;
      no_target    <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here so every register sees pre-edge values.
      no_target <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pos        <= '0;
            x          <= '0;
            y          <= '0;
            best_found <= 1'b0;
            best_key   <= '0;
            best_pos   <= '0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (take) begin
            best_key <= cur_key;
            best_pos <= pos;
            best_x   <= x;
            best_y   <= y;
            best_den <= cur_den;
          end
          best_found <= found_nx;
          pos        <= pos + 7'd1;
          if (x == 4'd9) begin
            x <= '0;
            y <= y + 4'd1;
          end else begin
            x <= x + 4'd1;
          end
          // The final cell's result is folded in here, not a cycle later.
          if (last) begin
            if (found_nx) begin
              shot_valid   <= 1'b1;
              shot_pos     <= take ? pos     : best_pos;
              shot_x       <= take ? x       : best_x;
              shot_y       <= take ? y       : best_y;
              shot_density <= take ? cur_den : best_den;
            end else begin
              no_target <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        OFFER: begin
          if (shot_ready) begin
            shot_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ai_target_select.sv
// Self-checking bench for ai_target_select: directed and randomized density maps
// checked against a whole-map argmax reference model.
module tb_ai_target_select;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [99:0][5:0] dens;
  logic [99:0]      fired;
  logic             shot_ready;
  logic             busy, shot_valid, no_target;
  logic [6:0]       shot_pos;
  logic [3:0]       shot_x, shot_y;
  logic [5:0]       shot_density;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ai_target_select dut (
    .clk(clk), .rst_n(rst_n), .start(start), .density(dens), .fired(fired),
    .shot_ready(shot_ready), .busy(busy), .shot_valid(shot_valid),
    .shot_pos(shot_pos), .shot_x(shot_x), .shot_y(shot_y),
    .shot_density(shot_density), .no_target(no_target)
  );

  // Reference: highest key among unfired cells, first occurrence wins.
  function automatic int model_best();
    int best = -1;
    int bk = -1;
    for (int p = 0; p < 100; p++) begin
      if (!fired[p]) begin
        int k;
        k = int'(dens[p]);
`ifdef AI_PARITY_EN
        k = k * 2 + ((((p % 10) + (p / 10)) % 2 == 0) ? 1 : 0);
`endif
        if (k > bk) begin
          bk = k;
          best = p;
        end
      end
    end
    return best;
  endfunction

  task automatic fill_random(input int dmax, input int fire_pct);
    for (int p = 0; p < 100; p++) begin
      dens[p]  = 6'($urandom_range(0, dmax));
      fired[p] = ($urandom_range(0, 99) < fire_pct);
    end
  endtask

  // Pulse start, wait for the result with a bound, and check it against the model.
  task automatic run_scan(input string name, output int got_idx);
    int exp_idx, n;
    bit got;
    exp_idx = model_best();
    got_idx = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    n = 0;
    got = 0;
    while (!got && n < 200) begin
      @(posedge clk); #1 n++;
      if (shot_valid === 1'b1 || no_target === 1'b1) got = 1;
    end
    vectors++;
    if (n != 100) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want 100", name, n);
    end
    if (exp_idx < 0) begin
      vectors++;
      if (no_target !== 1'b1 || shot_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s no_target_end: got nt=%b v=%b busy=%b want 1 0 0",
                 name, no_target, shot_valid, busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (no_target !== 1'b0 || shot_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s no_target_pulse: got nt=%b v=%b want 0 0", name, no_target, shot_valid);
      end
    end else begin
      got_idx = int'(shot_pos);
      vectors++;
      if (shot_valid !== 1'b1 || no_target !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s offer_flags: got v=%b nt=%b busy=%b want 1 0 1",
                 name, shot_valid, no_target, busy);
      end
      vectors++;
      if (shot_pos !== 7'(exp_idx) || shot_x !== 4'(exp_idx % 10) ||
          shot_y !== 4'(exp_idx / 10) || shot_density !== dens[exp_idx]) begin
        miscompares++;
        $display("FAIL %s shot: got pos=%0d x=%0d y=%0d d=%0d want pos=%0d x=%0d y=%0d d=%0d",
                 name, shot_pos, shot_x, shot_y, shot_density,
                 exp_idx, exp_idx % 10, exp_idx / 10, dens[exp_idx]);
      end
    end
  endtask

  // Complete the handshake and check the offer is withdrawn with the shot retained.
  task automatic accept(input string name, input int idx);
    shot_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (shot_valid !== 1'b0 || busy !== 1'b0 || shot_pos !== 7'(idx)) begin
      miscompares++;
      $display("FAIL %s accept: got v=%b busy=%b pos=%0d want 0 0 %0d",
               name, shot_valid, busy, shot_pos, idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; shot_ready = 1'b0; dens = '0; fired = '0;
    #12;
    vectors++;
    if ({busy, shot_valid, no_target, shot_pos, shot_x, shot_y, shot_density} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got busy=%b v=%b nt=%b pos=%0d x=%0d y=%0d d=%0d want all 0",
               busy, shot_valid, no_target, shot_pos, shot_x, shot_y, shot_density);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_unique_max();
    int g;
    for (int p = 0; p < 100; p++) dens[p] = 6'd1;
    dens[57] = 6'd9; fired = '0; shot_ready = 1'b1;
    run_scan("unique_max", g);
    vectors++;
    if (g != 57 || shot_x !== 4'd7 || shot_y !== 4'd5 || shot_density !== 6'd9) begin
      miscompares++;
      $display("FAIL unique_max_const: got pos=%0d x=%0d y=%0d d=%0d want 57 7 5 9",
               g, shot_x, shot_y, shot_density);
    end
    accept("unique_max", 57);
  endtask

  task automatic test_fired_skip();
    int g;
    dens = '0; fired = '0;
    dens[57] = 6'd9; fired[57] = 1'b1; dens[3] = 6'd8;
    run_scan("fired_skip", g);
    vectors++;
    if (g != 3 || shot_density !== 6'd8) begin
      miscompares++;
      $display("FAIL fired_skip_const: got pos=%0d d=%0d want 3 8", g, shot_density);
    end
    accept("fired_skip", 3);
  endtask

  task automatic test_tie();
    int g;
    dens = '0; fired = '0;
    dens[11] = 6'd5; dens[12] = 6'd5;
    run_scan("tie_a", g);
    vectors++;
    if (g != 11) begin
      miscompares++;
      $display("FAIL tie_a_const: got pos=%0d want 11", g);
    end
    accept("tie_a", g);
    dens[11] = 6'd0; dens[13] = 6'd5;
    run_scan("tie_b", g);
    vectors++;
`ifdef AI_PARITY_EN
    if (g != 13) begin
      miscompares++;
      $display("FAIL tie_b_const: got pos=%0d want 13", g);
    end
`else
    if (g != 12) begin
      miscompares++;
      $display("FAIL tie_b_const: got pos=%0d want 12", g);
    end
`endif
    accept("tie_b", g);
  endtask

  task automatic test_all_fired();
    int g;
    fill_random(63, 0);
    fired = '1;
    run_scan("all_fired", g);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (shot_valid !== 1'b0 || busy !== 1'b0 || no_target !== 1'b0) begin
        miscompares++;
        $display("FAIL all_fired_after: got v=%b busy=%b nt=%b want 0 0 0",
                 shot_valid, busy, no_target);
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [6:0] held;
    fill_random(63, 30);
    shot_ready = 1'b0;
    run_scan("backpressure", g);
    held = shot_pos;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = (i == 5);
      vectors++;
      if (shot_valid !== 1'b1 || shot_pos !== held || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL backpressure_hold: got v=%b pos=%0d busy=%b want 1 %0d 1",
                 shot_valid, shot_pos, busy, held);
      end
    end
    start = 1'b0;
    accept("backpressure", int'(held));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || shot_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_idle: got busy=%b v=%b want 0 0", busy, shot_valid);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int g;
    fill_random(63, 20);
    shot_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, shot_valid, no_target, shot_pos, shot_x, shot_y, shot_density} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_scan: got busy=%b v=%b nt=%b pos=%0d x=%0d y=%0d d=%0d want all 0",
               busy, shot_valid, no_target, shot_pos, shot_x, shot_y, shot_density);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    fill_random(63, 20);
    run_scan("after_reset", g);
    accept("after_reset", g);
  endtask

  task automatic test_back_to_back();
    int g;
    shot_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: fill_random(63, 20);
        1: fill_random(2, 50);
        2: fill_random(0, 10);
        default: fill_random(63, 97);
      endcase
      run_scan("random", g);
      if (g >= 0) accept("random", g);
    end
  endtask

  initial begin
    test_reset();
    test_unique_max();
    test_fired_skip();
    test_tie();
    test_all_fired();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
